// File: rtl/gpu_seq_pkg.sv
// Shared types and constants for the per-unit GPU job sequencer.
package gpu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StExec,
    StWrC
  } seq_state_e;

  localparam logic [3:0] OP_MATMUL = 4'd0;
  localparam logic [3:0] OP_EWADD  = 4'd1;

  // op_config field layout; M/N/K fields hold dimension-1
  localparam int unsigned CFG_FIELD_W = 4;
  localparam int unsigned CFG_M_LSB   = 0;
  localparam int unsigned CFG_N_LSB   = 4;
  localparam int unsigned CFG_K_LSB   = 8;
  localparam int unsigned CFG_OP_LSB  = 12;

endpackage

// File: rtl/gpu_seq_addr_gen.sv
// Element byte-address calculation for the A, B and C operands of the current (i, j, k).
module gpu_seq_addr_gen
  import gpu_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_a_base,
  input  logic [ADDR_WIDTH-1:0] i_b_base,
  input  logic [ADDR_WIDTH-1:0] i_c_base,
  input  logic [3:0]            i_row,
  input  logic [3:0]            i_col,
  input  logic [3:0]            i_kidx,
  input  logic [3:0]            i_n_m1,
  input  logic [3:0]            i_k_m1,
  input  logic [3:0]            i_opcode,
  output logic [ADDR_WIDTH-1:0] o_a_addr,
  output logic [ADDR_WIDTH-1:0] o_b_addr,
  output logic [ADDR_WIDTH-1:0] o_c_addr
);

  logic [7:0] w_n;
  logic [7:0] w_k;
  logic [7:0] w_idx_a;
  logic [7:0] w_idx_b;
  logic [7:0] w_idx_c;
  logic       w_is_matmul;

  // Indices stay below 256 since every dimension is at most 16.
  always_comb begin
    w_n         = 8'(i_n_m1) + 8'd1;
    w_k         = 8'(i_k_m1) + 8'd1;
    w_is_matmul = (i_opcode == OP_MATMUL);
    w_idx_c     = 8'(i_row) * w_n + 8'(i_col);
    w_idx_a     = w_is_matmul ? (8'(i_row) * w_k + 8'(i_kidx)) : w_idx_c;
    w_idx_b     = w_is_matmul ? (8'(i_kidx) * w_n + 8'(i_col)) : w_idx_c;
    o_a_addr    = i_a_base + ADDR_WIDTH'({w_idx_a, 2'b00});
    o_b_addr    = i_b_base + ADDR_WIDTH'({w_idx_b, 2'b00});
    o_c_addr    = i_c_base + ADDR_WIDTH'({w_idx_c, 2'b00});
  end

endmodule

// File: rtl/gpu_unit_sequencer.sv
// Per-unit job engine: matmul / element-wise add over a single-outstanding word memory port.
module gpu_unit_sequencer
  import gpu_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_soft_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [ADDR_WIDTH-1:0] i_c_addr,
  input  logic [15:0]           i_op_config,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [31:0]           o_cycle_count,
  output logic [31:0]           o_op_count,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_err
);

  seq_state_e            r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_a_base, r_b_base, r_c_base;
  logic [3:0]            r_m_m1, r_n_m1, r_k_m1, r_opcode;
  logic [3:0]            r_i, r_j, r_k, w_i_d, w_j_d, w_k_d;
  logic [DATA_WIDTH-1:0] r_a_val, r_b_val, r_acc, w_a_val_d, w_b_val_d, w_acc_d;
  logic                  r_busy, r_done, r_error, w_done_d, w_error_d;
  logic [31:0]           r_cycle_count, r_op_count;
  logic                  r_mem_req, r_mem_we, w_mem_req_d, w_mem_we_d;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_d;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_d;

  logic                  w_start_ok, w_cfg_bad;
  logic [ADDR_WIDTH-1:0] w_a_base, w_b_base, w_c_base;
  logic [3:0]            w_n_m1, w_k_m1, w_opcode;
  logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b, w_addr_c;
  logic [DATA_WIDTH-1:0] w_mac, w_sum;

  assign w_start_ok = (r_state == StIdle) && i_start && i_enable && !i_soft_reset;
  assign w_cfg_bad  = (i_op_config[CFG_OP_LSB +: CFG_FIELD_W] > OP_EWADD) ||
                      (|i_a_addr[1:0]) || (|i_b_addr[1:0]) || (|i_c_addr[1:0]);

  // The first address of a job is computed in the start cycle, before the config is captured.
  assign w_a_base = (r_state == StIdle) ? i_a_addr : r_a_base;
  assign w_b_base = (r_state == StIdle) ? i_b_addr : r_b_base;
  assign w_c_base = (r_state == StIdle) ? i_c_addr : r_c_base;
  assign w_n_m1   = (r_state == StIdle) ? i_op_config[CFG_N_LSB +: CFG_FIELD_W] : r_n_m1;
  assign w_k_m1   = (r_state == StIdle) ? i_op_config[CFG_K_LSB +: CFG_FIELD_W] : r_k_m1;
  assign w_opcode = (r_state == StIdle) ? i_op_config[CFG_OP_LSB +: CFG_FIELD_W] : r_opcode;

  assign w_mac = r_acc + r_a_val * r_b_val;
  assign w_sum = r_a_val + r_b_val;

  // Addresses follow the next-state indices so requests are valid on state entry.
  gpu_seq_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .i_a_base (w_a_base),
    .i_b_base (w_b_base),
    .i_c_base (w_c_base),
    .i_row    (w_i_d),
    .i_col    (w_j_d),
    .i_kidx   (w_k_d),
    .i_n_m1   (w_n_m1),
    .i_k_m1   (w_k_m1),
    .i_opcode (w_opcode),
    .o_a_addr (w_addr_a),
    .o_b_addr (w_addr_b),
    .o_c_addr (w_addr_c)
  );

  // Next state, loop indices, datapath and sticky status.
  always_comb begin
    w_state_d     = r_state;
    w_i_d         = r_i;
    w_j_d         = r_j;
    w_k_d         = r_k;
    w_a_val_d     = r_a_val;
    w_b_val_d     = r_b_val;
    w_acc_d       = r_acc;
    w_done_d      = r_done;
    w_error_d     = r_error;
    w_mem_wdata_d = r_mem_wdata;
    unique case (r_state)
      StIdle: begin
        if (w_start_ok) begin
          w_done_d  = 1'b0;
          w_error_d = 1'b0;
          w_i_d     = '0;
          w_j_d     = '0;
          w_k_d     = '0;
          w_acc_d   = '0;
          if (w_cfg_bad) w_error_d = 1'b1;
          else           w_state_d = StRdA;
        end
      end
      StRdA: begin
        if (i_mem_ack) begin
          if (i_mem_err) begin
            w_error_d = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_a_val_d = i_mem_rdata;
            w_state_d = StRdB;
          end
        end
      end
      StRdB: begin
        if (i_mem_ack) begin
          if (i_mem_err) begin
            w_error_d = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_b_val_d = i_mem_rdata;
            w_state_d = StExec;
          end
        end
      end
      StExec: begin
        w_acc_d       = w_mac;
        w_mem_wdata_d = (r_opcode == OP_MATMUL) ? w_mac : w_sum;
        if ((r_opcode == OP_MATMUL) && (r_k != r_k_m1)) begin
          w_k_d     = r_k + 4'd1;
          w_state_d = StRdA;
        end else begin
          w_state_d = StWrC;
        end
      end
      StWrC: begin
        if (i_mem_ack) begin
          if (i_mem_err) begin
            w_error_d = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_acc_d = '0;
            w_k_d   = '0;
            if (r_j != r_n_m1) begin
              w_j_d     = r_j + 4'd1;
              w_state_d = StRdA;
            end else if (r_i != r_m_m1) begin
              w_i_d     = r_i + 4'd1;
              w_j_d     = '0;
              w_state_d = StRdA;
            end else begin
              w_done_d  = 1'b1;
              w_state_d = StIdle;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (i_soft_reset) begin
      w_state_d = StIdle;
      w_done_d  = 1'b0;
      w_error_d = 1'b0;
    end
  end

  // Memory request for the state being entered; held while waiting for ack.
  always_comb begin
    w_mem_req_d  = 1'b0;
    w_mem_we_d   = 1'b0;
    w_mem_addr_d = r_mem_addr;
    unique case (w_state_d)
      StRdA: begin
        w_mem_req_d  = 1'b1;
        w_mem_addr_d = w_addr_a;
      end
      StRdB: begin
        w_mem_req_d  = 1'b1;
        w_mem_addr_d = w_addr_b;
      end
      StWrC: begin
        w_mem_req_d  = 1'b1;
        w_mem_we_d   = 1'b1;
        w_mem_addr_d = w_addr_c;
      end
      default: ;
    endcase
  end

  // State, captured job config, datapath registers, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_a_base      <= '0;
      r_b_base      <= '0;
      r_c_base      <= '0;
      r_m_m1        <= '0;
      r_n_m1        <= '0;
      r_k_m1        <= '0;
      r_opcode      <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_a_val       <= '0;
      r_b_val       <= '0;
      r_acc         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cycle_count <= '0;
      r_op_count    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_i         <= w_i_d;
      r_j         <= w_j_d;
      r_k         <= w_k_d;
      r_a_val     <= w_a_val_d;
      r_b_val     <= w_b_val_d;
      r_acc       <= w_acc_d;
      r_busy      <= (w_state_d != StIdle);
      r_done      <= w_done_d;
      r_error     <= w_error_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      if (w_start_ok) begin
        r_a_base <= i_a_addr;
        r_b_base <= i_b_addr;
        r_c_base <= i_c_addr;
        r_m_m1   <= i_op_config[CFG_M_LSB +: CFG_FIELD_W];
        r_n_m1   <= i_op_config[CFG_N_LSB +: CFG_FIELD_W];
        r_k_m1   <= i_op_config[CFG_K_LSB +: CFG_FIELD_W];
        r_opcode <= i_op_config[CFG_OP_LSB +: CFG_FIELD_W];
      end
      if (i_soft_reset) begin
        r_cycle_count <= '0;
        r_op_count    <= '0;
      end else begin
        r_cycle_count <= r_cycle_count + {31'd0, r_busy};
        r_op_count    <= r_op_count + {31'd0, (r_state == StExec)};
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_cycle_count = r_cycle_count;
  assign o_op_count    = r_op_count;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_gpu_unit_sequencer.sv
// Directed bench for gpu_unit_sequencer with a 1-wait memory responder.
module tb_gpu_unit_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable, soft_reset, start;
  logic [31:0] a_addr, b_addr, c_addr;
  logic [15:0] op_config;
  logic        busy, done, error;
  logic [31:0] cycle_count, op_count;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack, mem_err;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // responder state
  logic [31:0] mem [0:255];
  logic [31:0] wr_log_addr [0:15];
  logic [31:0] wr_log_data [0:15];
  int          wr_count = 0;
  int          acc_cnt = 0;
  int          err_at = -1;
  int          req_cycles = 0;

  always #5 clk = ~clk;

  gpu_unit_sequencer #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_soft_reset  (soft_reset),
    .i_start       (start),
    .i_a_addr      (a_addr),
    .i_b_addr      (b_addr),
    .i_c_addr      (c_addr),
    .i_op_config   (op_config),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error),
    .o_cycle_count (cycle_count),
    .o_op_count    (op_count),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .i_mem_err     (mem_err)
  );

  // Acks one cycle after seeing a request; logs writes; optional error on access err_at.
  always @(posedge clk) begin
    if (rst) begin
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      if (mem_req) req_cycles <= req_cycles + 1;
      if (mem_req && !mem_ack) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[mem_addr[9:2]];
        mem_err   <= (acc_cnt == err_at);
        acc_cnt   <= acc_cnt + 1;
        if (mem_we && (acc_cnt != err_at)) begin
          wr_log_addr[wr_count[3:0]] <= mem_addr;
          wr_log_data[wr_count[3:0]] <= mem_wdata;
          wr_count <= wr_count + 1;
        end
      end
    end
  end

  task automatic start_job(input logic [15:0] cfg, input logic [31:0] a, b, c);
    @(posedge clk); #1;
    op_config = cfg; a_addr = a; b_addr = b; c_addr = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; soft_reset = 1'b0; start = 1'b0;
    a_addr = '0; b_addr = '0; c_addr = '0; op_config = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", error); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycle_count); end
    checks++; if (op_count !== 32'd0) begin errors++; $display("FAIL reset_ops: got %0d want 0", op_count); end
    checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_req_we: got %b want 00", {mem_req, mem_we}); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_matmul_1x1();
    bit to;
    mem[64] = 32'd3; mem[128] = 32'd5;
    start_job(16'h0000, 32'h100, 32'h200, 32'h300);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL mm1_timeout: got busy want idle"); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL mm1_status: got %b want 10", {done, error}); end
    checks++; if (op_count !== 32'd1) begin errors++; $display("FAIL mm1_ops: got %0d want 1", op_count); end
    checks++; if (cycle_count !== 32'd7) begin errors++; $display("FAIL mm1_cycles: got %0d want 7", cycle_count); end
    checks++; if (wr_count !== 1) begin errors++; $display("FAIL mm1_wr_count: got %0d want 1", wr_count); end
    checks++; if (wr_log_addr[0] !== 32'h300 || wr_log_data[0] !== 32'd15) begin
      errors++; $display("FAIL mm1_write: got %h=%0d want 300=15", wr_log_addr[0], wr_log_data[0]);
    end
  endtask

  task automatic test_matmul_2x2();
    bit to;
    int base;
    logic [31:0] exp_c [0:3];
    exp_c[0] = 32'd19; exp_c[1] = 32'd22; exp_c[2] = 32'd43; exp_c[3] = 32'd50;
    mem[64] = 1; mem[65] = 2; mem[66] = 3; mem[67] = 4;
    mem[128] = 5; mem[129] = 6; mem[130] = 7; mem[131] = 8;
    base = wr_count;
    start_job(16'h0111, 32'h100, 32'h200, 32'h300);
    // a start while busy and enable dropping mid-job must both be ignored
    @(posedge clk); #1;
    op_config = 16'h3000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; enable = 1'b0;
    wait_idle(to);
    enable = 1'b1;
    checks++; if (to) begin errors++; $display("FAIL mm2_timeout: got busy want idle"); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL mm2_status: got %b want 10", {done, error}); end
    checks++; if (op_count !== 32'd9) begin errors++; $display("FAIL mm2_ops: got %0d want 9", op_count); end
    checks++; if (cycle_count !== 32'd55) begin errors++; $display("FAIL mm2_cycles: got %0d want 55", cycle_count); end
    checks++; if (wr_count !== base + 4) begin errors++; $display("FAIL mm2_wr_count: got %0d want %0d", wr_count, base + 4); end
    for (int n = 0; n < 4; n++) begin
      logic [3:0] p;
      p = 4'(base + n);
      checks++;
      if (wr_log_addr[p] !== 32'h300 + 32'(4 * n) || wr_log_data[p] !== exp_c[n]) begin
        errors++;
        $display("FAIL mm2_c%0d: got %h=%0d want %h=%0d", n, wr_log_addr[p], wr_log_data[p],
                 32'h300 + 32'(4 * n), exp_c[n]);
      end
    end
  endtask

  task automatic test_ewadd();
    bit to;
    int base;
    logic [3:0] p0, p1;
    mem[64] = 32'h7FFF_FFFF; mem[65] = 32'd1;
    mem[128] = 32'd1; mem[129] = 32'd2;
    base = wr_count;
    p0 = 4'(base); p1 = 4'(base + 1);
    // K field set non-zero to show it is ignored
    start_job(16'h1510, 32'h100, 32'h200, 32'h300);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL ew_timeout: got busy want idle"); end
    checks++; if (op_count !== 32'd11) begin errors++; $display("FAIL ew_ops: got %0d want 11", op_count); end
    checks++; if (cycle_count !== 32'd69) begin errors++; $display("FAIL ew_cycles: got %0d want 69", cycle_count); end
    checks++; if (wr_log_addr[p0] !== 32'h300 || wr_log_data[p0] !== 32'h8000_0000) begin
      errors++; $display("FAIL ew_c0: got %h=%h want 300=80000000", wr_log_addr[p0], wr_log_data[p0]);
    end
    checks++; if (wr_log_addr[p1] !== 32'h304 || wr_log_data[p1] !== 32'd3) begin
      errors++; $display("FAIL ew_c1: got %h=%h want 304=3", wr_log_addr[p1], wr_log_data[p1]);
    end
  endtask

  task automatic test_cfg_error();
    int reqs;
    reqs = req_cycles;
    start_job(16'h3000, 32'h100, 32'h200, 32'h300);
    @(negedge clk);
    checks++; if ({busy, done, error} !== 3'b001) begin
      errors++; $display("FAIL cfg_op3: got busy/done/err %b want 001", {busy, done, error});
    end
    start_job(16'h0000, 32'h1002, 32'h200, 32'h300);
    @(negedge clk);
    checks++; if ({busy, error} !== 2'b01) begin
      errors++; $display("FAIL cfg_misalign: got busy/err %b want 01", {busy, error});
    end
    repeat (3) @(negedge clk);
    checks++; if (req_cycles !== reqs || busy !== 1'b0) begin
      errors++; $display("FAIL cfg_no_req: got %0d req cycles busy %0b want 0/0", req_cycles - reqs, busy);
    end
    checks++; if (cycle_count !== 32'd69) begin errors++; $display("FAIL cfg_cycles: got %0d want 69", cycle_count); end
  endtask

  task automatic test_mem_err();
    bit to;
    int base;
    logic [3:0] p;
    mem[64] = 32'd3; mem[128] = 32'd5;
    base = wr_count;
    err_at = acc_cnt + 1;
    start_job(16'h0000, 32'h100, 32'h200, 32'h300);
    wait_idle(to);
    err_at = -1;
    checks++; if (to) begin errors++; $display("FAIL merr_timeout: got busy want idle"); end
    checks++; if ({done, error, mem_req} !== 3'b010) begin
      errors++; $display("FAIL merr_status: got done/err/req %b want 010", {done, error, mem_req});
    end
    checks++; if (op_count !== 32'd11 || wr_count !== base) begin
      errors++; $display("FAIL merr_no_exec: got ops %0d writes %0d want 11/%0d", op_count, wr_count, base);
    end
    checks++; if (cycle_count !== 32'd73) begin errors++; $display("FAIL merr_cycles: got %0d want 73", cycle_count); end
    start_job(16'h0000, 32'h100, 32'h200, 32'h300);
    wait_idle(to);
    p = 4'(base);
    checks++; if (to) begin errors++; $display("FAIL retry_timeout: got busy want idle"); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL retry_status: got %b want 10", {done, error}); end
    checks++; if (wr_log_data[p] !== 32'd15 || op_count !== 32'd12 || cycle_count !== 32'd80) begin
      errors++; $display("FAIL retry_result: got data %0d ops %0d cycles %0d want 15/12/80",
                         wr_log_data[p], op_count, cycle_count);
    end
  endtask

  task automatic test_soft_reset();
    bit found;
    int base;
    base = wr_count;
    found = 1'b0;
    start_job(16'h0000, 32'h100, 32'h200, 32'h300);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'h200 && !mem_ack) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL srst_reach_rdb: got no RD_B request want one"); end
    // ack for this read lands in the same edge the soft reset is taken
    soft_reset = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++; if ({busy, mem_req, done, error} !== 4'b0000) begin
      errors++; $display("FAIL srst_status: got busy/req/done/err %b want 0000", {busy, mem_req, done, error});
    end
    checks++; if (cycle_count !== 32'd0 || op_count !== 32'd0) begin
      errors++; $display("FAIL srst_counters: got %0d/%0d want 0/0", cycle_count, op_count);
    end
    soft_reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, mem_req} !== 2'b00 || wr_count !== base) begin
      errors++; $display("FAIL srst_late_ack: got busy/req %b writes %0d want 00/%0d", {busy, mem_req}, wr_count, base);
    end
    checks++; if (cycle_count !== 32'd0 || op_count !== 32'd0) begin
      errors++; $display("FAIL srst_after: got %0d/%0d want 0/0", cycle_count, op_count);
    end
  endtask

  initial begin
    for (int n = 0; n < 256; n++) mem[n] = '0;
    test_reset();
    test_matmul_1x1();
    test_matmul_2x2();
    test_ewadd();
    test_cfg_error();
    test_mem_err();
    test_soft_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
